// File: rtl/aes_pkg.sv
// Shared AES datapath parameters, plus the block-to-word helper used by the output FIFO.
package aes_pkg;

    localparam int FIFO_DEPTH      = 4;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_W         = 128;
    localparam int WORD_W          = 32;

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int IDX_W  = $clog2(WORDS_PER_BLOCK);
    localparam int CNT_W  = $clog2(FIFO_DEPTH * WORDS_PER_BLOCK + 1);
    localparam int BCNT_W = $clog2(FIFO_DEPTH + 1);

    typedef logic [PTR_W-1:0]   ptr_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [BCNT_W-1:0]  bcnt_t;
    typedef logic [BLOCK_W-1:0] block_t;
    typedef logic [WORD_W-1:0]  word_t;

    // Word index 0 is the most significant word of the block.
    function automatic word_t word_of(input block_t blk, input idx_t idx);
        return blk[BLOCK_W - 1 - WORD_W * int'(idx) -: WORD_W];
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, word-index, occupancy and overflow bookkeeping for the block-in / word-out FIFO.
module fifo_ctrl
    import aes_pkg::*;
(
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic data_out_load,
    input  logic read_word,
    output logic wr_en,
    output ptr_t wr_ptr,
    output ptr_t rd_ptr,
    output idx_t word_idx,
    output cnt_t word_count,
    output logic fifo_full,
    output logic fifo_empty,
    output logic overflow
);

    // Handshake: data_out_load is a valid whose ready is !fifo_full; read_word
    // is a pop request honoured only while !fifo_empty. Clear overrides both.
    bcnt_t block_count;
    logic  pop;
    logic  free_blk;

    assign fifo_full  = (block_count == BCNT_W'(FIFO_DEPTH));
    assign fifo_empty = (word_count == '0);
    assign wr_en      = data_out_load & ~fifo_full & ~clear;
    assign pop        = read_word & ~fifo_empty & ~clear;
    assign free_blk   = pop && (word_idx == IDX_W'(WORDS_PER_BLOCK - 1));

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_idx    <= '0;
            word_count  <= '0;
            block_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (wr_en)    wr_ptr   <= wr_ptr + PTR_W'(1);
            if (pop)      word_idx <= word_idx + IDX_W'(1);
            if (free_blk) rd_ptr   <= rd_ptr + PTR_W'(1);
            block_count <= block_count + BCNT_W'(wr_en) - BCNT_W'(free_blk);
            word_count  <= word_count + (wr_en ? CNT_W'(WORDS_PER_BLOCK) : CNT_W'(0))
                           - CNT_W'(pop);
            // Sticky: a rejected write is an error even if a pop frees space this cycle.
            if (data_out_load && fifo_full) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/output_fifo.sv
// Output FIFO: takes 128-bit ciphertext blocks and hands them out as 32-bit words, MSW first.
module output_fifo
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                data_out_load,
    input  logic [BLOCK_W-1:0]  process_out_data,
    output logic                fifo_full,
    input  logic                read_word,
    output logic [WORD_W-1:0]   read_data,
    output logic                fifo_empty,
    output logic [CNT_W-1:0]    word_count,
    output logic                overflow
);

    block_t mem [FIFO_DEPTH];
    logic   wr_en;
    ptr_t   wr_ptr;
    ptr_t   rd_ptr;
    idx_t   word_idx;

    fifo_ctrl u_ctrl (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (clear),
        .data_out_load (data_out_load),
        .read_word     (read_word),
        .wr_en         (wr_en),
        .wr_ptr        (wr_ptr),
        .rd_ptr        (rd_ptr),
        .word_idx      (word_idx),
        .word_count    (word_count),
        .fifo_full     (fifo_full),
        .fifo_empty    (fifo_empty),
        .overflow      (overflow)
    );

    // Storage is never reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= process_out_data;
    end

    always_comb begin
        read_data = '0;
        if (!fifo_empty) read_data = word_of(mem[rd_ptr], word_idx);
    end

endmodule

// File: tb/tb_output_fifo.sv
// Self-checking bench for output_fifo: word-queue reference model plus directed and random stimulus.
module tb_output_fifo;

    logic         clk;
    logic         n_rst;
    logic         clear;
    logic         data_out_load;
    logic [127:0] process_out_data;
    logic         fifo_full;
    logic         read_word;
    logic [31:0]  read_data;
    logic         fifo_empty;
    logic [4:0]   word_count;
    logic         overflow;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    logic [31:0] exp_q[$];
    logic        exp_ovf = 1'b0;

    output_fifo dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .clear            (clear),
        .data_out_load    (data_out_load),
        .process_out_data (process_out_data),
        .fifo_full        (fifo_full),
        .read_word        (read_word),
        .read_data        (read_data),
        .fifo_empty       (fifo_empty),
        .word_count       (word_count),
        .overflow         (overflow)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Blocks held = ceil(words/4); full means four blocks held, i.e. more than 12 words.
    task automatic model_step(input logic rst_n, input logic clr, input logic ld,
                              input logic [127:0] d, input logic rd);
        bit full_now;
        bit empty_now;
        full_now  = exp_q.size() > 12;
        empty_now = exp_q.size() == 0;
        if (!rst_n || clr) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            if (rd && !empty_now) void'(exp_q.pop_front());
            if (ld && full_now) exp_ovf = 1'b1;
            if (ld && !full_now) begin
                exp_q.push_back(d[127:96]);
                exp_q.push_back(d[95:64]);
                exp_q.push_back(d[63:32]);
                exp_q.push_back(d[31:0]);
            end
        end
    endtask

    // ---------------- compare process ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("model_word_count", 32'(word_count), 32'(exp_q.size()));
            cmp("model_fifo_empty", 32'(fifo_empty), 32'(exp_q.size() == 0));
            cmp("model_fifo_full",  32'(fifo_full),  32'(exp_q.size() > 12));
            cmp("model_overflow",   32'(overflow),   32'(exp_ovf));
            cmp("model_read_data",  read_data, (exp_q.size() != 0) ? exp_q[0] : 32'h0);
        end
    end

    // ---------------- driver ----------------
    // Called at a falling edge; drives, takes one rising edge, returns at the next falling edge.
    task automatic cycle(input logic rst_n, input logic clr, input logic ld,
                         input logic [127:0] d, input logic rd);
        n_rst            = rst_n;
        clear            = clr;
        data_out_load    = ld;
        process_out_data = d;
        read_word        = rd;
        @(posedge clk);
        model_step(rst_n, clr, ld, d, rd);
        @(negedge clk);
        n_rst = 1'b1; clear = 1'b0; data_out_load = 1'b0; read_word = 1'b0;
    endtask

    function automatic logic [127:0] rnd_block();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [127:0] blk_a;
    logic [127:0] blk_b;
    logic [127:0] blk_x;
    logic [31:0]  exp_words [4];

    initial begin
        n_rst = 1'b0; clear = 1'b0; data_out_load = 1'b0; read_word = 1'b0;
        process_out_data = '0;
        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, rnd_block(), 1'b1);
        cmp_en = 1'b1;
        cmp("rst_word_count", 32'(word_count), 32'd0);
        cmp("rst_fifo_empty", 32'(fifo_empty), 32'd1);
        cmp("rst_fifo_full",  32'(fifo_full),  32'd0);
        cmp("rst_read_data",  read_data, 32'h0);
        cmp("rst_overflow",   32'(overflow), 32'd0);

        // Known vector, MSW-first order.
        blk_a = 128'h2ce2c3408ce0aca66e86b19ce60c0abc;
        exp_words[0] = 32'h2ce2c340; exp_words[1] = 32'h8ce0aca6;
        exp_words[2] = 32'h6e86b19c; exp_words[3] = 32'he60c0abc;
        cycle(1'b1, 1'b0, 1'b1, blk_a, 1'b0);
        cmp("vec_word_count", 32'(word_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cmp("vec_word", read_data, exp_words[i]);
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        end
        cmp("vec_empty", 32'(fifo_empty), 32'd1);
        cmp("vec_read_data_zero", read_data, 32'h0);

        // Fill to four blocks, then one rejected write.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, rnd_block(), 1'b0);
        cmp("fill_full", 32'(fifo_full), 32'd1);
        cmp("fill_count", 32'(word_count), 32'd16);
        blk_x = rnd_block();
        cycle(1'b1, 1'b0, 1'b1, blk_x, 1'b0);
        cmp("ovf_set", 32'(overflow), 32'd1);
        cmp("ovf_count", 32'(word_count), 32'd16);

        // Pop the head block: full drops after the 4th pop, then a write is accepted.
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cmp("pop3_still_full", 32'(fifo_full), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cmp("pop4_not_full", 32'(fifo_full), 32'd0);
        cmp("pop4_count", 32'(word_count), 32'd12);
        cycle(1'b1, 1'b0, 1'b1, rnd_block(), 1'b0);
        cmp("refill_count", 32'(word_count), 32'd16);
        cmp("ovf_sticky", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cmp("drain_empty", 32'(fifo_empty), 32'd1);
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
        cmp("clear_ovf", 32'(overflow), 32'd0);

        // Simultaneous write and pop with a partly consumed head block.
        blk_a = 128'h00112233_44556677_8899aabb_ccddeeff;
        blk_b = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        cycle(1'b1, 1'b0, 1'b1, blk_a, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cmp("wp_count_before", 32'(word_count), 32'd2);
        cycle(1'b1, 1'b0, 1'b1, blk_b, 1'b1);
        cmp("wp_count_after", 32'(word_count), 32'd5);
        cmp("wp_head", read_data, 32'hccddeeff);
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
        cmp("wp_next", read_data, 32'hdeadbeef);

        // Pops on an empty FIFO are ignored.
        cycle(1'b1, 1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
            cmp("empty_pop_count", 32'(word_count), 32'd0);
            cmp("empty_pop_data", read_data, 32'h0);
            cmp("empty_pop_ovf", 32'(overflow), 32'd0);
        end

        // Clear and reset each win over a concurrent write and pop.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, rnd_block(), 1'b0);
            cycle(1'b1, 1'b0, 1'b1, rnd_block(), 1'b0);
            cmp("pre_flush_ovf", 32'(overflow), 32'd1);
            cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
            if (pass == 0) cycle(1'b1, 1'b1, 1'b1, rnd_block(), 1'b1);
            else           cycle(1'b0, 1'b0, 1'b1, rnd_block(), 1'b1);
            cmp("flush_empty", 32'(fifo_empty), 32'd1);
            cmp("flush_count", 32'(word_count), 32'd0);
            cmp("flush_ovf", 32'(overflow), 32'd0);
            cmp("flush_data", read_data, 32'h0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 2) == 0), rnd_block(), ($urandom_range(0, 3) != 0));
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
